// File: rtl/pau_rr_scheduler.sv
// pau_rr_scheduler: shares one posit arithmetic unit (add/mul/div) between NREQ
// requesters with round-robin arbitration and at most one operation in flight.
// Each requester has its own request valid/ready pair and a private response
// valid/ready pair. The result is returned on a shared data bus.
// Optional feature: define PAU_SCHED_TIMEOUT_EN to abort an EXEC phase that never
// sees pau_done. The abort returns rsp_err=1 with NaR after TIMEOUT EXEC cycles.
module pau_rr_scheduler #(
    parameter int NREQ        = 4,
    parameter int N           = 16,
    parameter int WAIT_CYCLES = 3,
    parameter int TIMEOUT     = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [3*NREQ-1:0]   req_op,
    input  logic [N*NREQ-1:0]   req_a,
    input  logic [N*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [N-1:0]        rsp_data,
    output logic                rsp_err,
    output logic                pau_start,
    output logic [1:0]          pau_sel,
    output logic [N-1:0]        pau_a,
    output logic [N-1:0]        pau_b,
    input  logic [N-1:0]        pau_result,
    input  logic                pau_done,
    output logic                busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(WAIT_CYCLES + 2);
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_reg, state_next;
    logic [IDW-1:0]  last_grant_reg;
    logic [IDW-1:0]  id_reg;
    logic [IDW-1:0]  grant_id;
    logic            grant_valid;
    logic            accept;
    logic            exec_done;
    logic            timeout_hit;
    logic [CW-1:0]   cnt_reg;
    logic [N-1:0]    pau_a_reg, pau_b_reg, rsp_data_reg;
    logic [1:0]      pau_sel_reg, grant_sel;
    logic            rsp_err_reg;

    // Per-requester views of the flattened request buses.
    logic [2:0]      op_arr [NREQ];
    logic [N-1:0]    a_arr  [NREQ];
    logic [N-1:0]    b_arr  [NREQ];
    logic [2:0]      grant_op;
    logic [N-1:0]    grant_a, grant_b;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign op_arr[gi]    = req_op[gi*3 +: 3];
            assign a_arr[gi]     = req_a[gi*N +: N];
            assign b_arr[gi]     = req_b[gi*N +: N];
            // Ready is forced low while rst is asserted, so every output reads zero during reset.
            assign req_ready[gi] = !rst && (state_reg == IDLE) && grant_valid
                                   && (grant_id == IDW'(gi));
            assign rsp_valid[gi] = (state_reg == RESP) && (id_reg == IDW'(gi));
        end
    endgenerate

    // Round-robin search: first valid requester strictly after the last grant.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant_reg) + k) % NREQ;
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign grant_op = op_arr[grant_id];
    assign grant_a  = a_arr[grant_id];
    assign grant_b  = b_arr[grant_id];
    assign accept   = !rst && (state_reg == IDLE) && grant_valid;

    // Map the requester op to a PAU unit select. SUB shares the adder.
    always_comb begin
        case (grant_op[1:0])
            2'b10:   grant_sel = 2'b01;
            2'b11:   grant_sel = 2'b10;
            default: grant_sel = 2'b00;
        endcase
    end

    assign exec_done = (state_reg == EXEC) && (cnt_reg == CW'(WAIT_CYCLES)) && pau_done;

`ifdef PAU_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_reg;

    // Count EXEC cycles so that a unit which never reports done cannot stall the scheduler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_reg <= '0;
        end else if (accept) begin
            tcnt_reg <= '0;
        end else if (state_reg == EXEC) begin
            tcnt_reg <= tcnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == EXEC) && !exec_done && (tcnt_reg == TW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. Illegal ops bypass the PAU and go straight to RESP.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = grant_op[2] ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (exec_done || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[id_reg]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the granted request, run the settle counter, and capture the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= IDW'(NREQ - 1);
            id_reg         <= '0;
            cnt_reg        <= '0;
            pau_a_reg      <= '0;
            pau_b_reg      <= '0;
            pau_sel_reg    <= '0;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= 1'b0;
        end else if (accept) begin
            id_reg         <= grant_id;
            last_grant_reg <= grant_id;
            cnt_reg        <= '0;
            if (grant_op[2]) begin
                rsp_data_reg <= NAR;
                rsp_err_reg  <= 1'b1;
            end else begin
                // Operands change only for ops that start the PAU, so the PAU inputs stay quiet otherwise.
                pau_a_reg   <= grant_a;
                pau_b_reg   <= (grant_op[1:0] == 2'b01) ? (N'(0) - grant_b) : grant_b;
                pau_sel_reg <= grant_sel;
            end
        end else if (state_reg == EXEC) begin
            if (cnt_reg != CW'(WAIT_CYCLES)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (exec_done) begin
                rsp_data_reg <= pau_result;
                rsp_err_reg  <= 1'b0;
            end else if (timeout_hit) begin
                rsp_data_reg <= NAR;
                rsp_err_reg  <= 1'b1;
            end
        end
    end

    assign pau_start = (state_reg == EXEC);
    assign pau_sel   = pau_sel_reg;
    assign pau_a     = pau_a_reg;
    assign pau_b     = pau_b_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_pau_rr_scheduler.sv
// Self-checking bench for pau_rr_scheduler (default build, timeout feature off).
// It runs a table of single-requester vectors, then hand sequences for backpressure,
// reset during EXEC and fairness. It finishes with randomized traffic checked against
// a transaction-level round-robin model.
module tb_pau_rr_scheduler;

    localparam int NREQ = 4;
    localparam int N    = 16;
    localparam int WAIT = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3*NREQ-1:0]   req_op;
    logic [N*NREQ-1:0]   req_a, req_b;
    logic [N-1:0]        rsp_data, pau_a, pau_b, pau_result;
    logic                rsp_err, pau_start, pau_done, busy;
    logic [1:0]          pau_sel;

    int tests = 0;
    int fails = 0;
    int model_lg;

    pau_rr_scheduler #(.NREQ(NREQ), .N(N), .WAIT_CYCLES(WAIT), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .pau_start(pau_start), .pau_sel(pau_sel), .pau_a(pau_a), .pau_b(pau_b),
        .pau_result(pau_result), .pau_done(pau_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] grant;
        logic            start;
        logic [1:0]      sel;
        logic [N-1:0]    pa, pb;
        int              lat;
        logic [NREQ-1:0] rv;
        logic [N-1:0]    data;
        logic            err;
        bit              stable;
        bit              ready_zero;
        logic [NREQ-1:0] after_rv;
        bit              hold;
    } obs_t;

    typedef struct {
        int           id;
        logic [2:0]   op;
        logic [N-1:0] a, b, res;
        logic [1:0]   exp_sel;
        logic [N-1:0] exp_pb;
        logic         exp_err;
        logic [N-1:0] exp_data;
    } vec_t;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Round-robin rule: the first requesting index after the last grant, wrapping.
    function automatic int rr_pick(int lg, logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(lg + k) % NREQ]) return (lg + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [1:0] sel_of(logic [2:0] op);
        if (op == 3'd2) return 2'b01;
        if (op == 3'd3) return 2'b10;
        return 2'b00;
    endfunction

    // Drive one request set and follow the granted operation through to the response handshake.
    // d = EXEC cycles before pau_done rises. r = cycles of response backpressure.
    task automatic run_txn(input logic [NREQ-1:0] mask, input logic [3*NREQ-1:0] ops,
                           input logic [N*NREQ-1:0] av, input logic [N*NREQ-1:0] bv,
                           input logic [N-1:0] res, input int d, input int r, output obs_t o);
        int k;
        req_valid = mask; req_op = ops; req_a = av; req_b = bv;
        pau_result = res; pau_done = (d == 0);
        #1;
        o.grant = req_ready;
        @(posedge clk); #1;
        req_valid = mask & ~o.grant;
        o.start = pau_start; o.sel = pau_sel; o.pa = pau_a; o.pb = pau_b;
        o.ready_zero = 1;
        k = 0;
        while (rsp_valid == '0 && k < 200) begin
            if (req_ready != '0) o.ready_zero = 0;
            @(posedge clk); #1;
            k++;
            pau_done = (k >= d);
        end
        o.lat = k; o.rv = rsp_valid; o.data = rsp_data; o.err = rsp_err;
        o.stable = 1;
        for (int i = 0; i < r; i++) begin
            rsp_ready = NREQ'($urandom) & ~o.rv;
            @(posedge clk); #1;
            if (rsp_valid !== o.rv || rsp_data !== o.data || rsp_err !== o.err || req_ready != '0)
                o.stable = 0;
        end
        rsp_ready = o.rv;
        @(posedge clk); #1;
        rsp_ready = '0; pau_done = 1'b0;
        o.after_rv = rsp_valid;
        o.hold = (pau_sel == o.sel && pau_a == o.pa && pau_b == o.pb && pau_start == 1'b0 && busy == 1'b0);
        req_valid = '0;
    endtask

    task automatic check_txn(string tag, obs_t o, int id, logic legal, logic [1:0] sel,
                             logic [N-1:0] pa, logic [N-1:0] pb, logic err,
                             logic [N-1:0] data, int lat);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << id;
        check({tag, ".grant"}, 32'(o.grant), 32'(oh));
        if (legal) begin
            check({tag, ".start"}, 32'(o.start), 32'd1);
            check({tag, ".sel"},   32'(o.sel),   32'(sel));
            check({tag, ".pau_a"}, 32'(o.pa),    32'(pa));
            check({tag, ".pau_b"}, 32'(o.pb),    32'(pb));
            check({tag, ".hold"},  32'(o.hold),  32'd1);
        end
        check({tag, ".latency"},    32'(o.lat),        32'(lat));
        check({tag, ".rsp_valid"},  32'(o.rv),         32'(oh));
        check({tag, ".rsp_data"},   32'(o.data),       32'(data));
        check({tag, ".rsp_err"},    32'(o.err),        32'(err));
        check({tag, ".stable"},     32'(o.stable),     32'd1);
        check({tag, ".ready_zero"}, 32'(o.ready_zero), 32'd1);
        check({tag, ".released"},   32'(o.after_rv),   32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        obs_t o;
        logic [3*NREQ-1:0] ops;
        logic [N*NREQ-1:0] av, bv;
        logic [NREQ-1:0]   mask;
        logic [N-1:0]      res, bw, exp_pb;
        logic [2:0]        op;
        int                id, d, r, exp_lat;
        int                fair_exp[5];
        bit                legal;

        vecs[0] = '{0, 3'b000, 16'h4000, 16'h4000, 16'h5000, 2'b00, 16'h4000, 1'b0, 16'h5000};
        vecs[1] = '{2, 3'b001, 16'h3000, 16'h4000, 16'h1234, 2'b00, 16'hC000, 1'b0, 16'h1234};
        vecs[2] = '{1, 3'b101, 16'h1111, 16'h2222, 16'h7777, 2'b00, 16'h0000, 1'b1, 16'h8000};
        vecs[3] = '{3, 3'b010, 16'h4800, 16'h3800, 16'h4400, 2'b01, 16'h3800, 1'b0, 16'h4400};
        vecs[4] = '{0, 3'b011, 16'h5000, 16'h4000, 16'h4800, 2'b10, 16'h4000, 1'b0, 16'h4800};
        vecs[5] = '{1, 3'b001, 16'h4000, 16'h8000, 16'h8000, 2'b00, 16'h8000, 1'b0, 16'h8000};
        vecs[6] = '{2, 3'b111, 16'h0101, 16'h0202, 16'h3333, 2'b00, 16'h0000, 1'b1, 16'h8000};
        vecs[7] = '{3, 3'b001, 16'h2000, 16'h0001, 16'h0abc, 2'b00, 16'hFFFF, 1'b0, 16'h0abc};
        fair_exp = '{0, 1, 2, 3, 0};

        rst = 1'b1; req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
        pau_result = '0; pau_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.req_ready", 32'(req_ready), 32'd0);
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset.pau_start", 32'(pau_start), 32'd0);
        check("reset.busy",      32'(busy),      32'd0);
        check("reset.rsp_data",  32'(rsp_data),  32'd0);
        check("reset.pau_ab",    32'({pau_a, pau_b}), 32'd0);
        rst = 1'b0;
        model_lg = NREQ - 1;

        // Table of single-requester vectors with small backpressure.
        for (int i = 0; i < 8; i++) begin
            id = vecs[i].id;
            ops = '0; av = '0; bv = '0;
            ops[id*3 +: 3] = vecs[i].op;
            av[id*N +: N]  = vecs[i].a;
            bv[id*N +: N]  = vecs[i].b;
            run_txn(NREQ'(1) << id, ops, av, bv, vecs[i].res, 0, i % 3, o);
            legal = !vecs[i].op[2];
            exp_lat = legal ? WAIT + 1 : 0;
            check_txn($sformatf("vec%0d", i), o, id, legal, vecs[i].exp_sel, vecs[i].a,
                      vecs[i].exp_pb, vecs[i].exp_err, vecs[i].exp_data, exp_lat);
            $display("[TB] vec%0d id=%0d op=%b data=%h err=%b lat=%0d", i, id, vecs[i].op,
                     o.data, o.err, o.lat);
            model_lg = id;
        end

        // Backpressure: 10 stalled cycles while the other requesters keep asking.
        ops = '0; av = {4{16'h4000}}; bv = {4{16'h3000}};
        mask = 4'b1111;
        id = rr_pick(model_lg, mask);
        run_txn(mask, ops, av, bv, 16'h4321, 0, 10, o);
        check_txn("bp", o, id, 1'b1, 2'b00, 16'h4000, 16'h3000, 1'b0, 16'h4321, WAIT + 1);
        $display("[TB] backpressure id=%0d data=%h", id, o.data);
        model_lg = id;

        // Reset while in EXEC: the operation is dropped and outputs clear at once.
        req_valid = 4'b0100; req_op = '0; req_a = {4{16'h1357}}; req_b = {4{16'h2468}};
        pau_done = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        check("rstx.start", 32'(pau_start), 32'd1);
        @(posedge clk); #1;
        req_valid = 4'b1111; rst = 1'b1;
        #1;
        check("rstx.pau_start", 32'(pau_start), 32'd0);
        check("rstx.busy",      32'(busy),      32'd0);
        check("rstx.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstx.req_ready", 32'(req_ready), 32'd0);
        check("rstx.pau_ab",    32'({pau_a, pau_b}), 32'd0);
        check("rstx.rsp",       32'({rsp_err, rsp_data}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;
        model_lg = NREQ - 1;
        $display("[TB] reset during EXEC applied");

        // Fairness: all requesters held high, one grant each per round.
        for (int i = 0; i < 5; i++) begin
            res = N'($urandom);
            run_txn(4'b1111, '0, {4{16'h4000}}, {4{16'h4000}}, res, 0, 0, o);
            check_txn($sformatf("fair%0d", i), o, fair_exp[i], 1'b1, 2'b00, 16'h4000, 16'h4000,
                      1'b0, res, WAIT + 1);
            $display("[TB] fair%0d grant=%b", i, o.grant);
            model_lg = fair_exp[i];
        end

        // Randomized traffic against the transaction-level model.
        for (int t = 0; t < 40; t++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int q = 0; q < NREQ; q++) begin
                int x;
                x = $urandom_range(0, 9);
                ops[q*3 +: 3] = (x < 8) ? 3'(x % 4) : 3'(4 + $urandom_range(0, 3));
                av[q*N +: N]  = N'($urandom);
                bv[q*N +: N]  = N'($urandom);
            end
            res = N'($urandom);
            d = $urandom_range(0, 6);
            r = $urandom_range(0, 3);
            id = rr_pick(model_lg, mask);
            op = ops[id*3 +: 3];
            bw = bv[id*N +: N];
            legal = !op[2];
            exp_pb = (op == 3'd1) ? (N'(0) - bw) : bw;
            exp_lat = legal ? ((d > WAIT ? d : WAIT) + 1) : 0;
            run_txn(mask, ops, av, bv, res, d, r, o);
            check_txn($sformatf("rnd%0d", t), o, id, legal, sel_of(op), av[id*N +: N], exp_pb,
                      !legal, legal ? res : 16'h8000, exp_lat);
            $display("[TB] rnd%0d mask=%b id=%0d op=%b d=%0d data=%h err=%b lat=%0d",
                     t, mask, id, op, d, o.data, o.err, o.lat);
            model_lg = id;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
